// File: rtl/text_writer_pkg.sv
// Shared constants for the text-mode character writer: control codes,
// printable range and FSM state encodings.
package text_writer_pkg;

   localparam logic [7:0] CHAR_BS  = 8'h08;
   localparam logic [7:0] CHAR_LF  = 8'h0A;
   localparam logic [7:0] CHAR_FF  = 8'h0C;
   localparam logic [7:0] CHAR_CR  = 8'h0D;

   localparam logic [7:0] PRINT_LO = 8'h20;
   localparam logic [7:0] PRINT_HI = 8'h7E;

   typedef enum logic [1:0] {
      S_CLR_ALL  = 2'd0,
      S_IDLE     = 2'd1,
      S_CLR_LINE = 2'd2
   } state_t;

   function automatic logic is_printable(input logic [7:0] c);
      return (c >= PRINT_LO) && (c <= PRINT_HI);
   endfunction

endpackage

// File: rtl/text_writer_if.sv
// Byte-stream input, character-RAM write port and cursor position of the
// text writer, bundled for connection between source/RAM side and block.
interface text_writer_if #(
   parameter int ADDR_WIDTH = 11,
   parameter int COLS       = 40,
   parameter int ROWS       = 30
) ();

   logic                       in_valid;
   logic [7:0]                 in_data;
   logic                       in_ready;
   logic                       write_en;
   logic [ADDR_WIDTH-1:0]      waddr;
   logic [7:0]                 din;
   logic [$clog2(COLS)-1:0]    cur_col;
   logic [$clog2(ROWS)-1:0]    cur_row;

   modport master (
      output in_valid, in_data,
      input  in_ready, write_en, waddr, din, cur_col, cur_row
   );

   modport slave (
      input  in_valid, in_data,
      output in_ready, write_en, waddr, din, cur_col, cur_row
   );

endinterface

// File: rtl/text_writer.sv
// Character-terminal front end: consumes ASCII bytes and fills the text
// buffer RAM one write per cycle, tracking the cursor without a multiplier.
module text_writer
   import text_writer_pkg::*;
#(
   parameter int         ADDR_WIDTH = 11,
   parameter int         COLS       = 40,
   parameter int         ROWS       = 30,
   parameter logic [7:0] BLANK      = 8'h20
) (
   input  logic           clk,
   input  logic           rstn,
   text_writer_if.slave   bus
);

   localparam int CW    = $clog2(COLS);
   localparam int RW    = $clog2(ROWS);
   localparam int TOTAL = COLS * ROWS;
   localparam int NW    = $clog2(TOTAL + 1);

   state_t                 r_state, w_state_nxt;
   logic [NW-1:0]          r_cnt, w_cnt_nxt;
   logic [CW-1:0]          r_col, w_col_nxt;
   logic [RW-1:0]          r_row, w_row_nxt;
   logic [ADDR_WIDTH-1:0]  r_lbase, w_lbase_nxt;
   logic                   r_we, w_we_nxt;
   logic [ADDR_WIDTH-1:0]  r_waddr, w_waddr_nxt;
   logic [7:0]             r_din, w_din_nxt;
   logic                   r_ready, w_ready_nxt;

   logic                   w_accept;
   logic                   w_print;
   logic                   w_newline;
   logic                   w_last_row;
   logic [RW-1:0]          w_row_adv;
   logic [ADDR_WIDTH-1:0]  w_lbase_adv;
   logic [ADDR_WIDTH-1:0]  w_cur_addr;

   assign w_accept    = bus.in_valid & r_ready & (r_state == S_IDLE);
   assign w_print     = is_printable(bus.in_data);
   // A printable byte in the last column wraps exactly like a line feed.
   assign w_newline   = (bus.in_data == CHAR_LF) |
                        (w_print & (r_col == CW'(COLS - 1)));
   assign w_last_row  = (r_row == RW'(ROWS - 1));
   assign w_row_adv   = w_last_row ? '0 : r_row + RW'(1);
   assign w_lbase_adv = w_last_row ? '0 : r_lbase + ADDR_WIDTH'(COLS);
   assign w_cur_addr  = r_lbase + ADDR_WIDTH'(r_col);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state <= S_CLR_ALL;
         r_cnt   <= '0;
         r_col   <= '0;
         r_row   <= '0;
         r_lbase <= '0;
         r_we    <= 1'b0;
         r_waddr <= '0;
         r_din   <= '0;
         r_ready <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_col   <= w_col_nxt;
         r_row   <= w_row_nxt;
         r_lbase <= w_lbase_nxt;
         r_we    <= w_we_nxt;
         r_waddr <= w_waddr_nxt;
         r_din   <= w_din_nxt;
         r_ready <= w_ready_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_col_nxt   = r_col;
      w_row_nxt   = r_row;
      w_lbase_nxt = r_lbase;
      case (r_state)
         S_CLR_ALL: begin
            // Counter reaching TOTAL is the idle turnaround cycle after the last write.
            if (r_cnt == NW'(TOTAL)) begin
               w_state_nxt = S_IDLE;
               w_cnt_nxt   = '0;
               w_col_nxt   = '0;
               w_row_nxt   = '0;
               w_lbase_nxt = '0;
            end else begin
               w_cnt_nxt = r_cnt + NW'(1);
            end
         end
         S_IDLE: begin
            if (w_accept) begin
               if (w_newline) begin
                  w_col_nxt   = '0;
                  w_row_nxt   = w_row_adv;
                  w_lbase_nxt = w_lbase_adv;
                  w_cnt_nxt   = '0;
                  w_state_nxt = S_CLR_LINE;
               end else if (w_print) begin
                  w_col_nxt = r_col + CW'(1);
               end else if (bus.in_data == CHAR_CR) begin
                  w_col_nxt = '0;
               end else if (bus.in_data == CHAR_BS) begin
                  if (r_col != '0) w_col_nxt = r_col - CW'(1);
               end else if (bus.in_data == CHAR_FF) begin
                  w_cnt_nxt   = '0;
                  w_state_nxt = S_CLR_ALL;
               end
            end
         end
         S_CLR_LINE: begin
            if (r_cnt == NW'(COLS)) begin
               w_state_nxt = S_IDLE;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + NW'(1);
            end
         end
         default: begin
            w_state_nxt = S_CLR_ALL;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   always_comb begin
      w_we_nxt    = 1'b0;
      w_waddr_nxt = r_waddr;
      w_din_nxt   = r_din;
      w_ready_nxt = (w_state_nxt == S_IDLE);
      case (r_state)
         S_CLR_ALL: begin
            if (r_cnt != NW'(TOTAL)) begin
               w_we_nxt    = 1'b1;
               w_waddr_nxt = ADDR_WIDTH'(r_cnt);
               w_din_nxt   = BLANK;
            end
         end
         S_IDLE: begin
            if (w_accept) begin
               if (w_print) begin
                  w_we_nxt    = 1'b1;
                  w_waddr_nxt = w_cur_addr;
                  w_din_nxt   = bus.in_data;
               end else if ((bus.in_data == CHAR_BS) && (r_col != '0)) begin
                  w_we_nxt    = 1'b1;
                  w_waddr_nxt = w_cur_addr - ADDR_WIDTH'(1);
                  w_din_nxt   = BLANK;
               end
            end
         end
         S_CLR_LINE: begin
            if (r_cnt != NW'(COLS)) begin
               w_we_nxt    = 1'b1;
               w_waddr_nxt = r_lbase + ADDR_WIDTH'(r_cnt);
               w_din_nxt   = BLANK;
            end
         end
         default: ;
      endcase
   end

   assign bus.in_ready = r_ready;
   assign bus.write_en = r_we;
   assign bus.waddr    = r_waddr;
   assign bus.din      = r_din;
   assign bus.cur_col  = r_col;
   assign bus.cur_row  = r_row;

endmodule

// File: doc/text_writer.md
Name: text_writer

Overview:
- Character-terminal front end that fills the text-mode character buffer RAM through that RAM's write port (write_en, waddr, din).
- Accepts a stream of ASCII bytes over a valid/ready handshake.
- Maintains a cursor, and performs screen clear, line clear, carriage return, line feed and backspace by issuing one RAM write per cycle.
- The display side reads the same RAM independently; this block never reads it.

Parameters:
- ADDR_WIDTH, 11, width of waddr; COLS*ROWS must not exceed 2**ADDR_WIDTH.
- COLS, 40, characters per text row.
- ROWS, 30, text rows per screen.
- BLANK, 8'h20, code written when clearing cells.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rstn  in  1  asynchronous active-low reset.
- in_valid  in  1  in_data holds a byte to consume.
- in_data  in  8  ASCII byte.
- in_ready  out  1  block can accept a byte this cycle.
- write_en  out  1  RAM write strobe.
- waddr  out  ADDR_WIDTH  RAM write address = row*COLS + col.
- din  out  8  RAM write data.
- cur_col  out  $clog2(COLS)  cursor column.
- cur_row  out  $clog2(ROWS)  cursor row.

Behaviour:
- All outputs are registered.
- While rstn=0: write_en=0, waddr=0, din=0, in_ready=0, cur_col=0, cur_row=0, state=CLR_ALL with clear counter=0.
- Address arithmetic:
  - No multiplier.
  - A line_base register holds cur_row*COLS. It adds COLS on row advance and returns to 0 on wrap from ROWS-1.
  - waddr = line_base + cur_col, truncated to ADDR_WIDTH.
- Handshake:
  - in_ready=1 only in IDLE.
  - A byte is accepted on a rising edge where in_valid & in_ready.
  - In_data is ignored when not accepted.
  - Back-to-back accepts are allowed while the state stays IDLE.
- States:
  - CLR_ALL: writes BLANK to addresses 0..COLS*ROWS-1, one per cycle, write_en=1. After the last write: cursor=(0,0), line_base=0, go to IDLE.
  - IDLE: in_ready=1. write_en=1 only in the cycle after an accept that produces a write; otherwise 0.
  - CLR_LINE: writes BLANK to line_base+0 .. line_base+COLS-1 for the (new) cursor row, COLS cycles, write_en=1. Then go to IDLE with cur_col=0.
- Byte decode on accept at edge N; the RAM write, if any, is driven during cycle N+1:
  - 0x20..0x7E (printable):
    - Write in_data at the current cursor.
    - If cur_col<COLS-1: cur_col+1, stay IDLE.
    - If cur_col=COLS-1: perform newline (below).
  - 0x0D CR: cur_col=0, no write.
  - 0x0A LF: newline:
    - cur_col=0.
    - cur_row+1, wrapping ROWS-1 -> 0 (line_base likewise).
    - Enter CLR_LINE for the new row.
  - 0x08 BS:
    - If cur_col>0: cur_col-1 and write BLANK at the new position.
    - If cur_col=0: no-op, no write.
  - 0x0C FF: enter CLR_ALL; cursor ends at (0,0).
  - Any other byte: accepted and discarded, no write, no cursor change.
- Printable at the last column: the character write occurs in cycle N+1, and the line clear starts in cycle N+2. in_ready is 0 from N+1 until CLR_LINE completes.
- No scrolling: the screen wraps circularly at the bottom; the newly entered row is always cleared.
- Reset asserted mid-operation (any state): outputs drop immediately. After release, a full CLR_ALL restarts from address 0.
- The first full clear after reset takes COLS*ROWS cycles (1200 at defaults) before in_ready first rises.

Decomposition:
- Shared include file holds:
  - control-code localparams: CHAR_BS=8'h08, CHAR_LF=8'h0A, CHAR_FF=8'h0C, CHAR_CR=8'h0D;
  - printable range bounds;
  - state encodings S_CLR_ALL, S_IDLE, S_CLR_LINE.
- No sub-module: the cursor/line_base counters and the FSM live in one module.

Test Plan:
- Reset release, in_valid=0 -> exactly 1200 writes, waddr 0..1199 in order, din=0x20; in_ready=0 throughout, in_ready=1 on the cycle after the last write; cursor (0,0).
- Send 0x41 at IDLE -> next cycle write_en=1, waddr=0, din=0x41; cur_col=1; in_ready stays 1; a second byte accepted the following cycle writes waddr=1.
- Send 40 bytes 0x78 from (0,0) -> writes waddr 0..39 with 0x78, then 40 writes waddr 40..79 with 0x20; in_ready low for 41 cycles; cursor (0,1).
- Cursor at (7,29), send 0x0A -> no character write; 40 BLANK writes waddr 0..39; cursor (0,0); 0x0D at (12,3) -> no write, cursor (0,3).
- Cursor at (5,2), send 0x08 -> write waddr=84, din=0x20, cursor (4,2); cursor at (0,2), send 0x08 -> no write, cursor unchanged; send 0x07 -> accepted, no effect.
- Send 0x0C mid-screen -> 1200-write clear, cursor (0,0). Separately, assert rstn=0 during CLR_LINE -> write_en=0 immediately; after release, full clear restarts at waddr=0.
